// File: rtl/stop_watch_pkg.sv
// stop_watch_pkg: shared BCD digit type, direction enum and load-saturation helper
package stop_watch_pkg;
  typedef logic [3:0] bcd_t;
  localparam bcd_t BCD_MAX = 4'd9;
  typedef enum logic {DIR_UP = 1'b0, DIR_DN = 1'b1} dir_t;
  function automatic bcd_t bcd_sat(bcd_t v);
    return v > BCD_MAX ? BCD_MAX : v;
  endfunction
endpackage

// File: rtl/bcd_digit.sv
// bcd_digit: one BCD counter digit (clk, reset_n, clr, ld/d load, en tick, dir, cin in; q digit, cout carry/borrow out)
module bcd_digit
  import stop_watch_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clr,
  input  logic       ld,
  input  logic [3:0] d,
  input  logic       en,
  input  logic       dir,
  input  logic       cin,
  output logic [3:0] q,
  output logic       cout
);
  assign cout = cin & (dir == DIR_DN ? q == 4'd0 : q == BCD_MAX);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) q <= '0;
    else if (clr) q <= '0;
    else if (ld) q <= bcd_sat(d);
    else if (en && cin) q <= dir == DIR_DN ? (q == 4'd0 ? BCD_MAX : q - 4'd1) : (q == BCD_MAX ? 4'd0 : q + 4'd1);
endmodule

// File: rtl/stop_watch_gen.sv
// stop_watch_gen: prescaled NDIG-digit BCD up/down stopwatch (in: clk, reset_n, go, clr, dir, ld, ld_val, lap; out: digits, frozen, wrap, done)
module stop_watch_gen
  import stop_watch_pkg::*;
#(
  parameter int NDIG = 4,
  parameter int DVSR = 5_000_000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              go,
  input  logic              clr,
  input  logic              dir,
  input  logic              ld,
  input  logic [4*NDIG-1:0] ld_val,
  input  logic              lap,
  output logic [4*NDIG-1:0] digits,
  output logic              frozen,
  output logic              wrap,
  output logic              done
);
  localparam int PW = $clog2(DVSR);
  localparam logic [PW-1:0] LAST = PW'(DVSR - 1);
  logic [PW-1:0] pcnt;
  logic [NDIG:0] c;
  logic [4*NDIG-1:0] count, snap;
  logic tick, step, at_end, near_zero;
  assign tick = go && pcnt == LAST;
  assign c[0] = 1'b1;
  // c[NDIG] is all-9s when counting up and all-0s when counting down
  assign at_end = c[NDIG];
  assign step = tick && !(dir == DIR_DN && at_end);
  assign near_zero = (count >> 4) == '0 && count[3:0] <= 4'd1;
  for (genvar i = 0; i < NDIG; i++) begin : g_dig
    bcd_digit u_dig (
      .clk    (clk),
      .reset_n(reset_n),
      .clr    (clr),
      .ld     (ld),
      .d      (ld_val[4*i +: 4]),
      .en     (step),
      .dir    (dir),
      .cin    (c[i]),
      .q      (count[4*i +: 4]),
      .cout   (c[i+1])
    );
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) pcnt <= '0;
    else if (clr || ld) pcnt <= '0;
    else if (go) pcnt <= tick ? '0 : pcnt + 1'b1;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      wrap <= 1'b0;
      done <= 1'b0;
      frozen <= 1'b0;
      snap <= '0;
    end else if (clr) begin
      wrap <= 1'b0;
      done <= 1'b0;
      frozen <= 1'b0;
    end else begin
      if (lap) begin
        frozen <= !frozen;
        if (!frozen) snap <= count;
      end
      if (ld) begin
        wrap <= 1'b0;
        done <= 1'b0;
      end else begin
        wrap <= tick && dir == DIR_UP && at_end;
        if (tick && dir == DIR_DN && near_zero) done <= 1'b1;
      end
    end
  assign digits = frozen ? snap : count;
endmodule

// File: tb/tb_stop_watch_gen.sv
// tb_stop_watch_gen: self-checking bench for stop_watch_gen with NDIG=3, DVSR=4
module tb_stop_watch_gen;
  logic clk = 1'b0, reset_n = 1'b0, go = 1'b0, clr = 1'b0, dir = 1'b0, ld = 1'b0, lap = 1'b0;
  logic [11:0] ld_val = '0;
  logic [11:0] digits;
  logic frozen, wrap, done;
  int cmp_n = 0, fail_n = 0;
  int m_pc = 0, m_val = 0, m_snap = 0;
  bit m_frz = 0, m_wrap = 0, m_done = 0;
  typedef struct {logic [11:0] d; logic f, w, dn;} exp_t;
  exp_t sb[$];
  typedef struct {logic g, c, d, l; logic [11:0] lv; logic lp; logic [11:0] ed; logic ef, ew, edn;} vec_t;
  vec_t tbl[7];
  stop_watch_gen #(.NDIG(3), .DVSR(4)) dut (
    .clk(clk), .reset_n(reset_n), .go(go), .clr(clr), .dir(dir), .ld(ld),
    .ld_val(ld_val), .lap(lap), .digits(digits), .frozen(frozen), .wrap(wrap), .done(done)
  );
  always #5 clk = ~clk;
  function automatic logic [11:0] to_bcd(int v);
    return {4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction
  function automatic int sat(logic [11:0] v);
    logic [3:0] a, b, e;
    a = v[11:8] > 9 ? 4'd9 : v[11:8];
    b = v[7:4] > 9 ? 4'd9 : v[7:4];
    e = v[3:0] > 9 ? 4'd9 : v[3:0];
    return a * 100 + b * 10 + e;
  endfunction
  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    cmp_n++;
    if (a !== e) begin
      fail_n++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask
  task automatic step(input logic g, c, d, l, input logic [11:0] lv, input logic lp);
    bit tk;
    exp_t e;
    go = g; clr = c; dir = d; ld = l; ld_val = lv; lap = lp;
    tk = g && m_pc == 3;
    if (c) begin
      m_pc = 0; m_val = 0; m_done = 0; m_wrap = 0; m_frz = 0;
    end else begin
      if (lp) begin
        if (m_frz) m_frz = 0;
        else begin m_snap = m_val; m_frz = 1; end
      end
      if (l) begin
        m_pc = 0; m_val = sat(lv); m_done = 0; m_wrap = 0;
      end else begin
        if (g) m_pc = tk ? 0 : m_pc + 1;
        m_wrap = 0;
        if (tk && !d) begin
          if (m_val == 999) begin m_val = 0; m_wrap = 1; end
          else m_val++;
        end else if (tk) begin
          if (m_val > 0) m_val--;
          if (m_val == 0) m_done = 1;
        end
      end
    end
    sb.push_back('{to_bcd(m_frz ? m_snap : m_val), m_frz, m_wrap, m_done});
    @(negedge clk);
    e = sb.pop_front();
    chk("digits", 32'(digits), 32'(e.d));
    chk("frozen", 32'(frozen), 32'(e.f));
    chk("wrap", 32'(wrap), 32'(e.w));
    chk("done", 32'(done), 32'(e.dn));
  endtask
  task automatic chk_now(string n, logic [11:0] d, logic f, w, dn);
    chk({n, ".digits"}, 32'(digits), 32'(d));
    chk({n, ".frozen"}, 32'(frozen), 32'(f));
    chk({n, ".wrap"}, 32'(wrap), 32'(w));
    chk({n, ".done"}, 32'(done), 32'(dn));
  endtask
  initial begin
    tbl[0] = '{0, 1, 0, 1, 12'hA3F, 0, 12'h000, 0, 0, 0};
    tbl[1] = '{0, 0, 0, 1, 12'hA3F, 0, 12'h939, 0, 0, 0};
    tbl[2] = '{0, 0, 0, 1, 12'h5C0, 0, 12'h590, 0, 0, 0};
    tbl[3] = '{0, 0, 0, 0, 12'h000, 1, 12'h590, 1, 0, 0};
    tbl[4] = '{0, 0, 0, 1, 12'h123, 0, 12'h590, 1, 0, 0};
    tbl[5] = '{0, 0, 0, 0, 12'h000, 1, 12'h123, 0, 0, 0};
    tbl[6] = '{0, 1, 0, 0, 12'h000, 1, 12'h000, 0, 0, 0};
    repeat (2) @(negedge clk);
    chk_now("reset", 12'h000, 0, 0, 0);
    reset_n = 1'b1;
    // 1: count up from reset
    for (int i = 0; i < 40; i++) step(1, 0, 0, 0, 0, 0);
    chk_now("up10", 12'h010, 0, 0, 0);
    // 2: wrap
    step(1, 0, 0, 1, 12'h998, 0);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0, 0);
    chk_now("to999", 12'h999, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0, 0);
    chk_now("wrap", 12'h000, 0, 1, 0);
    step(1, 0, 0, 0, 0, 0);
    chk_now("wrap_end", 12'h000, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0);
    chk_now("after_wrap", 12'h001, 0, 0, 0);
    // 3: countdown
    step(1, 0, 1, 1, 12'h002, 0);
    for (int i = 0; i < 4; i++) step(1, 0, 1, 0, 0, 0);
    chk_now("dn1", 12'h001, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 0, 1, 0, 0, 0);
    chk_now("dn0", 12'h000, 0, 0, 1);
    for (int i = 0; i < 8; i++) step(1, 0, 1, 0, 0, 0);
    chk_now("dn_hold", 12'h000, 0, 0, 1);
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0);
    chk_now("done_sticky", 12'h001, 0, 0, 1);
    step(0, 1, 0, 0, 0, 0);
    chk_now("clr", 12'h000, 0, 0, 0);
    // 4: saturation, priority, lap vs ld/clr
    foreach (tbl[k]) begin
      step(tbl[k].g, tbl[k].c, tbl[k].d, tbl[k].l, tbl[k].lv, tbl[k].lp);
      chk_now($sformatf("tbl%0d", k), tbl[k].ed, tbl[k].ef, tbl[k].ew, tbl[k].edn);
    end
    // 5: lap freeze
    step(1, 0, 0, 1, 12'h014, 0);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0, 0);
    chk_now("lap_pre", 12'h015, 0, 0, 0);
    step(1, 0, 0, 0, 0, 1);
    chk_now("lap_on", 12'h015, 1, 0, 0);
    for (int i = 0; i < 8; i++) step(1, 0, 0, 0, 0, 0);
    chk_now("lap_hold", 12'h015, 1, 0, 0);
    step(1, 0, 0, 0, 0, 1);
    chk_now("lap_off", 12'h017, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 1);
    chk_now("lap_tick", 12'h017, 1, 0, 0);
    step(1, 0, 0, 0, 0, 1);
    chk_now("lap_tick_off", 12'h018, 0, 0, 0);
    // 6: pause and async reset
    step(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) step(0, 0, 0, 0, 0, 0);
    chk_now("pause", 12'h001, 0, 0, 0);
    step(1, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 0);
    #2 reset_n = 1'b0;
    #1 chk_now("async_rst", 12'h000, 0, 0, 0);
    m_pc = 0; m_val = 0; m_snap = 0; m_frz = 0; m_wrap = 0; m_done = 0;
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) step(1, 0, 0, 0, 0, 0);
    chk_now("post_rst", 12'h002, 0, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, fail_n);
    $finish;
  end
endmodule
